// File: rtl/strip_frame_assembler.sv
// Packs runs of headered strip words into WORDS_PER_FRAME-payload frames with saturating status counters.
// Optional build macro STRIP_LINK_GATE_EN: words also need linked=1, and link loss mid-frame counts an abort.
module strip_frame_assembler #(
  parameter int                DATA_W          = 30,
  parameter int                HDR_W           = 4,
  parameter logic [HDR_W-1:0]  HEADER          = 4'hA,
  parameter int                WORDS_PER_FRAME = 4,
  parameter int                CNT_W           = 16
) (
  input  logic                                      clk160,
  input  logic                                      reset,
  input  logic [DATA_W-1:0]                         data_in,
  input  logic                                      linked,
  input  logic                                      clear_cnt,
  output logic [(DATA_W-HDR_W)*WORDS_PER_FRAME-1:0] frame_data,
  output logic                                      frame_valid,
  output logic                                      in_frame,
  output logic [CNT_W-1:0]                          frame_cnt,
  output logic [CNT_W-1:0]                          short_cnt,
  output logic [CNT_W-1:0]                          abort_cnt
);

  localparam int PAY_W   = DATA_W - HDR_W;
  localparam int FRAME_W = PAY_W * WORDS_PER_FRAME;
  localparam int IDX_W   = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

  if (WORDS_PER_FRAME < 2) begin : g_bad_words_per_frame
    $error("strip_frame_assembler: WORDS_PER_FRAME must be at least 2");
  end

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               shift_en, frame_done, short_inc, abort_inc;
  logic               word_ok, link_lost;
  logic [PAY_W-1:0]   payload;

  assign payload = data_in[PAY_W-1:0];

`ifdef STRIP_LINK_GATE_EN
  assign word_ok   = (data_in[DATA_W-1 -: HDR_W] == HEADER) && linked;
  // A partial frame implies linked was high last cycle, so low now means it just fell.
  assign link_lost = !linked;
`else
  logic unused_linked;
  assign unused_linked = linked;
  assign word_ok       = (data_in[DATA_W-1 -: HDR_W] == HEADER);
  assign link_lost     = 1'b0;
`endif

  always_ff @(posedge clk160) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    short_inc  = 1'b0;
    abort_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (word_ok) begin
          shift_en  = 1'b1;
          idx_nxt   = IDX_W'(1);
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (word_ok) begin
          shift_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt    = '0;
            frame_done = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          if (idx != '0) begin
            abort_inc = link_lost;
            short_inc = !link_lost;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign in_frame = (state == COLLECT);

  always_ff @(posedge clk160) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (shift_en) frame_data <= {frame_data[FRAME_W-PAY_W-1:0], payload};
    end
  end

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr)                 return '0;
    else if (inc && ~&cnt)   return cnt + 1'b1;
    else                     return cnt;
  endfunction

  always_ff @(posedge clk160) begin
    if (reset) begin
      frame_cnt <= '0;
      short_cnt <= '0;
    end else begin
      frame_cnt <= cnt_next(frame_cnt, frame_done, clear_cnt);
      short_cnt <= cnt_next(short_cnt, short_inc, clear_cnt);
    end
  end

`ifdef STRIP_LINK_GATE_EN
  always_ff @(posedge clk160) begin
    if (reset) abort_cnt <= '0;
    else       abort_cnt <= cnt_next(abort_cnt, abort_inc, clear_cnt);
  end
`else
  logic unused_abort;
  assign unused_abort = abort_inc;
  assign abort_cnt    = '0;
`endif

endmodule
